// File: rtl/regfile_dumper_pkg.sv
// Shared types for the register-file dump engine.
// State encoding and register-file geometry.
package regfile_dumper_pkg;

  localparam int AW   = 5;
  localparam int NREG = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/regfile_dumper.sv
// Walks FIRST..LAST through a spare register-file read port and
// streams (addr, data) pairs out over a valid/ready handshake.
module regfile_dumper
  import regfile_dumper_pkg::*;
#(
  parameter int W     = 32,
  parameter int FIRST = 0,
  parameter int LAST  = 31
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] rd_addr,
  input  logic [W-1:0]  rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [W-1:0]  out_data,
  output logic          busy,
  output logic          done
);

  localparam logic [AW-1:0] A_FIRST = AW'(FIRST);
  localparam logic [AW-1:0] A_LAST  = AW'(LAST);

  state_t        state, state_n;
  logic [AW-1:0] addr, addr_n;
  logic          cap;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr     <= A_FIRST;
      out_addr <= '0;
      out_data <= '0;
    end else begin
      state <= state_n;
      addr  <= addr_n;
      if (cap) begin
        out_addr <= addr;
        out_data <= rd_data;
      end
    end
  end

  always_comb begin
    state_n = state;
    addr_n  = addr;
    cap     = 1'b0;
    if (abort && state != IDLE) begin
      state_n = IDLE;
      addr_n  = A_FIRST;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_n = READ;
            addr_n  = A_FIRST;
          end
        end
        READ: begin
          cap     = 1'b1;
          state_n = SEND;
        end
        SEND: begin
          if (out_ready) begin
            // LAST <= 31, so the increment never wraps
            if (addr == A_LAST) begin
              state_n = DONE;
            end else begin
              addr_n  = addr + AW'(1);
              state_n = READ;
            end
          end
        end
        DONE: begin
          state_n = IDLE;
          addr_n  = A_FIRST;
        end
      endcase
    end
  end

  assign rd_addr   = addr;
  assign out_valid = (state == SEND);
  assign busy      = (state == READ) || (state == SEND);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_regfile_dumper.sv
// Scoreboard bench for regfile_dumper: a full-range instance
// and a single-word (31..31) instance share one register file.
module tb_regfile_dumper;
  import regfile_dumper_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start0, abort0, ready0;
  logic        valid0, busy0, done0;
  logic [4:0]  rdaddr0, oaddr0;
  logic [31:0] rddata0, odata0;
  logic        start1, abort1, ready1;
  logic        valid1, busy1, done1;
  logic [4:0]  rdaddr1, oaddr1;
  logic [31:0] rddata1, odata1;

  logic [31:0] rf [32];
  assign rddata0 = rf[rdaddr0];
  assign rddata1 = rf[rdaddr1];

  regfile_dumper #(.W(32), .FIRST(0), .LAST(31)) u0 (
    .clk(clk), .reset(reset), .start(start0), .abort(abort0),
    .rd_addr(rdaddr0), .rd_data(rddata0),
    .out_valid(valid0), .out_ready(ready0),
    .out_addr(oaddr0), .out_data(odata0),
    .busy(busy0), .done(done0)
  );

  regfile_dumper #(.W(32), .FIRST(31), .LAST(31)) u1 (
    .clk(clk), .reset(reset), .start(start1), .abort(abort1),
    .rd_addr(rdaddr1), .rd_data(rddata1),
    .out_valid(valid1), .out_ready(ready1),
    .out_addr(oaddr1), .out_data(odata1),
    .busy(busy1), .done(done1)
  );

  int checks = 0;
  int fails  = 0;
  logic [36:0] q0[$];
  logic [36:0] q1[$];
  int words1 = 0;
  int dones1 = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin : mon0
    logic [36:0] e;
    if (valid0 && ready0) begin
      if (q0.size() == 0) begin
        chk("q0_extra", oaddr0, 5'h1f - oaddr0 + 1'b1);
      end else begin
        e = q0.pop_front();
        chk("addr0", oaddr0, e[36:32]);
        chk("data0", odata0, e[31:0]);
      end
    end
  end

  always @(negedge clk) begin : mon1
    logic [36:0] e;
    if (done1) dones1++;
    if (valid1 && ready1) begin
      words1++;
      if (q1.size() == 0) begin
        chk("q1_extra", q1.size(), 1);
      end else begin
        e = q1.pop_front();
        chk("addr1", oaddr1, e[36:32]);
        chk("data1", odata1, e[31:0]);
      end
    end
  end

  task automatic push_all();
    for (int i = 0; i < 32; i++) q0.push_back({5'(i), rf[i]});
  endtask

  task automatic run0(input int stall_at, input int nstall,
                      input int abort_at, input int wr_at,
                      input logic [31:0] wr_val,
                      output int lat, output int dones,
                      output int nst);
    bit fin;
    bit wrote;
    fin = 0;
    wrote = 0;
    lat = 0;
    dones = 0;
    nst = 0;
    @(posedge clk); #1 start0 = 1; ready0 = 0;
    @(posedge clk); #1 start0 = 0;
    for (int c = 1; c <= 400 && !fin; c++) begin
      if (done0) begin
        dones++;
        if (lat == 0) lat = c;
      end
      if (!busy0 && !done0 && c > 1) begin
        fin = 1;
      end else if (valid0 && int'(oaddr0) == abort_at) begin
        ready0 = 0;
        abort0 = 1;
        @(posedge clk); #1 abort0 = 0;
        chk("ab_busy", busy0, 0);
        chk("ab_valid", valid0, 0);
        for (int k = 0; k < 3; k++) begin
          chk("ab_done", done0, 0);
          chk("ab_rdaddr", rdaddr0, 0);
          @(posedge clk); #1;
        end
        fin = 1;
      end else begin
        if (valid0 && int'(oaddr0) == wr_at && !wrote) begin
          rf[wr_at+1] = wr_val;
          wrote = 1;
        end
        if (valid0 && int'(oaddr0) == stall_at && nst < nstall) begin
          chk("bp_data", odata0, rf[stall_at]);
          nst++;
          ready0 = 0;
        end else begin
          ready0 = 1;
        end
        @(posedge clk); #1;
      end
    end
    chk("run_fin", fin, 1);
    ready0 = 0;
  endtask

  int lat, dn, ns;
  bit seen;

  initial begin
    reset  = 1;
    start0 = 0; abort0 = 0; ready0 = 0;
    start1 = 0; abort1 = 0; ready1 = 1;
    for (int i = 0; i < 32; i++) rf[i] = i * 32'h11111111;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", busy0, 0);
    chk("rst_valid", valid0, 0);
    chk("rst_done", done0, 0);
    chk("rst_oaddr", oaddr0, 0);
    chk("rst_odata", odata0, 0);
    chk("rst_rdaddr0", rdaddr0, 0);
    chk("rst_rdaddr1", rdaddr1, 31);
    reset = 0;

    // full dump, ready tied high
    push_all();
    run0(-1, 0, -1, -1, 32'h0, lat, dn, ns);
    chk("full_lat", lat, 65);
    chk("full_done", dn, 1);
    chk("full_left", q0.size(), 0);

    // backpressure on word 3
    rf[3] = 32'hDEADBEEF;
    push_all();
    run0(3, 5, -1, -1, 32'h0, lat, dn, ns);
    chk("bp_cycles", ns, 5);
    chk("bp_done", dn, 1);
    chk("bp_left", q0.size(), 0);

    // register write while word 9 is pending
    push_all();
    q0[10] = {5'd10, 32'hCAFEF00D};
    run0(-1, 0, -1, 9, 32'hCAFEF00D, lat, dn, ns);
    chk("wr_done", dn, 1);
    chk("wr_left", q0.size(), 0);

    // abort in SEND of word 7, then restart
    for (int i = 0; i < 7; i++) q0.push_back({5'(i), rf[i]});
    run0(-1, 0, 7, -1, 32'h0, lat, dn, ns);
    chk("ab_dones", dn, 0);
    chk("ab_left", q0.size(), 0);
    push_all();
    run0(-1, 0, -1, -1, 32'h0, lat, dn, ns);
    chk("re_done", dn, 1);
    chk("re_left", q0.size(), 0);

    // single word instance, start held 4 cycles
    q1.push_back({5'd31, rf[31]});
    @(posedge clk); #1 start1 = 1;
    repeat (4) @(posedge clk);
    #1 start1 = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("sw_words", words1, 1);
    chk("sw_dones", dones1, 1);
    q1.push_back({5'd31, rf[31]});
    start1 = 1;
    @(posedge clk); #1 start1 = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("sw_words2", words1, 2);
    chk("sw_dones2", dones1, 2);
    chk("sw_left", q1.size(), 0);

    // reset during READ of word 2
    q0.push_back({5'd0, rf[0]});
    q0.push_back({5'd1, rf[1]});
    @(posedge clk); #1 start0 = 1; ready0 = 1;
    @(posedge clk); #1 start0 = 0;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      if (busy0 && !valid0 && rdaddr0 == 5'd2) seen = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("mr_seen", seen, 1);
    reset = 1;
    @(posedge clk); #1;
    chk("mr_busy", busy0, 0);
    chk("mr_valid", valid0, 0);
    chk("mr_done", done0, 0);
    chk("mr_oaddr", oaddr0, 0);
    chk("mr_odata", odata0, 0);
    chk("mr_rdaddr", rdaddr0, 0);
    chk("mr_left", q0.size(), 0);
    reset = 0;
    ready0 = 0;
    push_all();
    run0(-1, 0, -1, -1, 32'h0, lat, dn, ns);
    chk("mr_lat", lat, 65);
    chk("mr_done2", dn, 1);
    chk("mr_left2", q0.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
